acc_mem_arbiter: RTL and testbench



---
 rtl/acc_mem_pkg.sv | 23 ++
 rtl/acc_rr_picker.sv | 36 +++
 rtl/acc_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_acc_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_mem_pkg.sv
// Shared types and constants for the accelerator memory arbiter.
// State encoding, default widths and HCB/ACB memory map.
package acc_mem_pkg;

  localparam int NUM_ACC_D  = 4;
  localparam int ADDR_W_D   = 16;
  localparam int RDATA_W_D  = 512;
  localparam int WDATA_W_D  = 32;
  localparam int RD_LAT_D   = 1;

  localparam logic [15:0] HCB_START  = 16'h0000;
  localparam logic [15:0] HCB_OFFSET = 16'h0040;
  localparam logic [15:0] ACB_START  = 16'h4000;
  localparam logic [15:0] ACB_OFFSET = 16'h0040;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/acc_rr_picker.sv
// Round-robin picker: first requester at or after ptr.
// Purely combinational; wraps modulo N.
module acc_rr_picker
  import acc_mem_pkg::*;
#(
  parameter int N  = NUM_ACC_D,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW:0] pos;

  // Scan N slots starting at ptr, keep the first hit
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N))
        pos = pos - (PW+1)'(N);
      if (!any && req[pos[PW-1:0]]) begin
        any               = 1'b1;
        grant[pos[PW-1:0]] = 1'b1;
        idx               = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter sharing the accelerator data-memory port.
// One transaction in flight; stalls in ISSUE while the CPU holds memory.
module acc_mem_arbiter
  import acc_mem_pkg::*;
#(
  parameter int NUM_ACC          = NUM_ACC_D,
  parameter int ADDR_SIZE        = ADDR_W_D,
  parameter int READ_DATA_SIZE   = RDATA_W_D,
  parameter int WRITE_DATA_SIZE  = WDATA_W_D,
  parameter int MEM_READ_LATENCY = RD_LAT_D
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_ACC-1:0]              acc_read_en,
  input  logic [NUM_ACC*ADDR_SIZE-1:0]    acc_read_addr,
  input  logic [NUM_ACC-1:0]              acc_write_en,
  input  logic [NUM_ACC*ADDR_SIZE-1:0]    acc_write_addr,
  input  logic [NUM_ACC*WRITE_DATA_SIZE-1:0] acc_write_data,
  output logic [READ_DATA_SIZE-1:0]       acc_read_data,
  output logic [NUM_ACC-1:0]              acc_read_data_valid,
  output logic [NUM_ACC-1:0]              acc_write_done,
  input  logic                            mem_busy,
  output logic                            mem_read_en,
  output logic [ADDR_SIZE-1:0]            mem_read_addr,
  input  logic [READ_DATA_SIZE-1:0]       mem_read_data,
  output logic                            mem_write_en,
  output logic [ADDR_SIZE-1:0]            mem_write_addr,
  output logic [WRITE_DATA_SIZE-1:0]      mem_write_data
);

  localparam int PW = $clog2(NUM_ACC);
  localparam int CW = $clog2(MEM_READ_LATENCY + 1);

  arb_state_t                 state;
  logic [PW-1:0]              rr_ptr;
  logic [PW-1:0]              gnt;
  logic                       op_wr;
  logic [ADDR_SIZE-1:0]       addr_q;
  logic [WRITE_DATA_SIZE-1:0] wdata_q;
  logic [CW-1:0]              lat_cnt;
  logic [READ_DATA_SIZE-1:0]  rdata_q;
  logic [NUM_ACC-1:0]         rvalid_q;
  logic [NUM_ACC-1:0]         wdone_q;

  logic [NUM_ACC-1:0]         req;
  logic [NUM_ACC-1:0]         pick_grant;
  logic [PW-1:0]              pick_idx;
  logic                       pick_any;
  logic                       pick_wr;
  logic [NUM_ACC-1:0]         gnt_oh;
  logic [PW-1:0]              next_ptr;
  logic                       issue;

  assign req = acc_read_en | acc_write_en;

  acc_rr_picker #(
    .N  (NUM_ACC),
    .PW (PW)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Writes win over a read from the same accelerator
  assign pick_wr  = |(pick_grant & acc_write_en);
  assign gnt_oh   = NUM_ACC'(1) << gnt;
  assign next_ptr = (gnt == PW'(NUM_ACC - 1)) ? '0 : gnt + 1'b1;
  assign issue    = (state == ISSUE) && !mem_busy;

  assign mem_read_en    = issue && !op_wr;
  assign mem_read_addr  = mem_read_en ? addr_q : '0;
  assign mem_write_en   = issue && op_wr;
  assign mem_write_addr = mem_write_en ? addr_q : '0;
  assign mem_write_data = mem_write_en ? wdata_q : '0;

  assign acc_read_data       = rdata_q;
  assign acc_read_data_valid = rvalid_q;
  assign acc_write_done      = wdone_q;

  // Arbitration FSM with latched transaction and response pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      op_wr    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lat_cnt  <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
      wdone_q  <= '0;
    end else begin
      rvalid_q <= '0;
      wdone_q  <= '0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            gnt     <= pick_idx;
            op_wr   <= pick_wr;
            addr_q  <= pick_wr
                     ? acc_write_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE]
                     : acc_read_addr[pick_idx*ADDR_SIZE +: ADDR_SIZE];
            wdata_q <= acc_write_data[pick_idx*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_busy) begin
            rr_ptr <= next_ptr;
            if (op_wr) begin
              wdone_q <= gnt_oh;
              state   <= RESP;
            end else begin
              lat_cnt <= CW'(1);
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == CW'(MEM_READ_LATENCY)) begin
            rdata_q  <= mem_read_data;
            rvalid_q <= gnt_oh;
            state    <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Scoreboard bench for acc_mem_arbiter.
// Directed transactions push expected events; a monitor pops and compares.
module tb_acc_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int RW = 512;
  localparam int WW = 32;
  localparam int L  = 1;

  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_RV = 2;
  localparam int K_WD = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    rd_en = '0;
  logic [N*AW-1:0] rd_addr = '0;
  logic [N-1:0]    wr_en = '0;
  logic [N*AW-1:0] wr_addr = '0;
  logic [N*WW-1:0] wr_data = '0;
  logic [RW-1:0]   acc_read_data;
  logic [N-1:0]    acc_read_data_valid;
  logic [N-1:0]    acc_write_done;
  logic            mem_busy = 1'b0;
  logic            mem_read_en;
  logic [AW-1:0]   mem_read_addr;
  logic [RW-1:0]   mem_read_data = '0;
  logic            mem_write_en;
  logic [AW-1:0]   mem_write_addr;
  logic [WW-1:0]   mem_write_data;

  acc_mem_arbiter #(
    .NUM_ACC          (N),
    .ADDR_SIZE        (AW),
    .READ_DATA_SIZE   (RW),
    .WRITE_DATA_SIZE  (WW),
    .MEM_READ_LATENCY (L)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .acc_read_en         (rd_en),
    .acc_read_addr       (rd_addr),
    .acc_write_en        (wr_en),
    .acc_write_addr      (wr_addr),
    .acc_write_data      (wr_data),
    .acc_read_data       (acc_read_data),
    .acc_read_data_valid (acc_read_data_valid),
    .acc_write_done      (acc_write_done),
    .mem_busy            (mem_busy),
    .mem_read_en         (mem_read_en),
    .mem_read_addr       (mem_read_addr),
    .mem_read_data       (mem_read_data),
    .mem_write_en        (mem_write_en),
    .mem_write_addr      (mem_write_addr),
    .mem_write_data      (mem_write_data)
  );

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  vec;
    logic [511:0] rdata;
  } ev_t;

  ev_t q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  int  t;
  logic [N-1:0] rv_seen = '0;
  logic [N-1:0] wd_seen = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [511:0] line_for(input logic [15:0] a);
    if (a == 16'h1000) return {64{8'hA5}};
    return {32{a}};
  endfunction

  // Memory model: data appears right after the command, held until reused
  always @(negedge clk)
    if (mem_read_en) mem_read_data = line_for(mem_read_addr);

  // Accelerators drop a request the cycle after its pulse
  always @(negedge clk) begin
    rv_seen = acc_read_data_valid;
    wd_seen = acc_write_done;
  end

  always @(posedge clk) begin
    #1;
    rd_en   = rd_en & ~rv_seen;
    wr_en   = wr_en & ~wd_seen;
    rv_seen = '0;
    wd_seen = '0;
  end

  task automatic push(input int kind, input int c, input logic [15:0] a,
                      input logic [31:0] wd, input logic [3:0] v,
                      input logic [511:0] rd);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a;
    e.wdata = wd; e.vec = v; e.rdata = rd;
    q.push_back(e);
  endtask

  task automatic exp_rd(input int c, input logic [15:0] a, input logic [3:0] v);
    push(K_RD, c, a, '0, '0, '0);
    push(K_RV, c + 2, '0, '0, v, line_for(a));
  endtask

  task automatic exp_wr(input int c, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] v);
    push(K_WR, c, a, d, '0, '0);
    push(K_WD, c + 1, '0, '0, v, '0);
  endtask

  task automatic chk(input string nm, input logic [511:0] got,
                     input logic [511:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on any event
  always @(negedge clk) begin : mon
    int   kind;
    int   nev;
    ev_t  e;
    logic ok;
    kind = -1;
    nev  = 0;
    if (mem_read_en)          begin kind = K_RD; nev++; end
    if (mem_write_en)         begin kind = K_WR; nev++; end
    if (|acc_read_data_valid) begin kind = K_RV; nev++; end
    if (|acc_write_done)      begin kind = K_WD; nev++; end
    n_vec++;
    if (nev > 1 || $countones(acc_read_data_valid | acc_write_done) > 1
        || (!mem_read_en && mem_read_addr != '0)
        || (!mem_write_en && (mem_write_addr != '0 || mem_write_data != '0))) begin
      n_bad++;
      $display("FAIL invariant cyc=%0d rd=%b wr=%b rv=%b wd=%b ra=%h wa=%h wdat=%h",
               cyc, mem_read_en, mem_write_en, acc_read_data_valid,
               acc_write_done, mem_read_addr, mem_write_addr, mem_write_data);
    end
    if (nev == 1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected event kind=%0d cyc=%0d", kind, cyc);
      end else begin
        e  = q.pop_front();
        ok = (e.kind == kind) && (e.cyc == cyc);
        if (ok) begin
          unique case (kind)
            K_RD: ok = (mem_read_addr == e.addr);
            K_WR: ok = (mem_write_addr == e.addr) && (mem_write_data == e.wdata);
            K_RV: ok = (acc_read_data_valid == e.vec) && (acc_read_data == e.rdata);
            default: ok = (acc_write_done == e.vec);
          endcase
        end
        if (!ok) begin
          n_bad++;
          $display("FAIL event got k=%0d c=%0d ra=%h wa=%h wd=%h rv=%b dn=%b rdat=%h want k=%0d c=%0d a=%h wd=%h v=%b rdat=%h",
                   kind, cyc, mem_read_addr, mem_write_addr, mem_write_data,
                   acc_read_data_valid, acc_write_done, acc_read_data,
                   e.kind, e.cyc, e.addr, e.wdata, e.vec, e.rdata);
        end
      end
    end
  end

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s timeout pending=%0d want=0", nm, q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; rd_en = '0; wr_en = '0; mem_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", acc_read_data, '0);
    chk("rst_rvalid", 512'(acc_read_data_valid), '0);
    chk("rst_wdone", 512'(acc_write_done), '0);
    chk("rst_rd_en", 512'(mem_read_en), '0);
    chk("rst_wr_en", 512'(mem_write_en), '0);
    chk("rst_addr", 512'({mem_read_addr, mem_write_addr, mem_write_data}), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read, acc 0
    @(posedge clk); #1;
    t = cyc;
    rd_addr[0*AW +: AW] = 16'h1000;
    rd_en[0] = 1'b1;
    exp_rd(t + 1, 16'h1000, 4'b0001);
    drain("single_read");

    // Single write, acc 2
    @(posedge clk); #1;
    t = cyc;
    wr_addr[2*AW +: AW] = 16'h5000;
    wr_data[2*WW +: WW] = 32'h5;
    wr_en[2] = 1'b1;
    exp_wr(t + 1, 16'h5000, 32'h5, 4'b0100);
    drain("single_write");

    // Round robin from reset: 0,1,2,3 then acc 0 again
    reset_dut();
    @(posedge clk); #1;
    t = cyc;
    for (int i = 0; i < N; i++)
      rd_addr[i*AW +: AW] = 16'h2000 + 16'(i) * 16'h0100;
    rd_en = 4'b1111;
    for (int i = 0; i < N; i++)
      exp_rd(t + 1 + 4*i, 16'h2000 + 16'(i) * 16'h0100, 4'(1 << i));
    exp_rd(t + 17, 16'h2000, 4'b0001);
    repeat (5) @(posedge clk); #1;
    rd_en[0] = 1'b1;
    drain("round_robin");

    // mem_busy for three ISSUE cycles
    @(posedge clk); #1;
    t = cyc;
    mem_busy = 1'b1;
    rd_addr[1*AW +: AW] = 16'h3000;
    rd_en[1] = 1'b1;
    exp_rd(t + 4, 16'h3000, 4'b0010);
    repeat (4) @(posedge clk); #1;
    mem_busy = 1'b0;
    drain("mem_busy");

    // acc 1 read+write together with acc 2 read and acc 3 write
    reset_dut();
    @(posedge clk); #1;
    t = cyc;
    rd_addr[1*AW +: AW] = 16'h7100;
    wr_addr[1*AW +: AW] = 16'h6000;
    wr_data[1*WW +: WW] = 32'h11;
    rd_addr[2*AW +: AW] = 16'h7200;
    wr_addr[3*AW +: AW] = 16'h7300;
    wr_data[3*WW +: WW] = 32'h33;
    rd_en = 4'b0110;
    wr_en = 4'b1010;
    exp_wr(t + 1, 16'h6000, 32'h11, 4'b0010);
    exp_rd(t + 4, 16'h7200, 4'b0100);
    exp_wr(t + 8, 16'h7300, 32'h33, 4'b1000);
    exp_rd(t + 11, 16'h7100, 4'b0010);
    drain("rd_wr_same");

    // Reset while in WAIT
    @(posedge clk); #1;
    t = cyc;
    rd_addr[0*AW +: AW] = 16'h1000;
    rd_en[0] = 1'b1;
    push(K_RD, t + 1, 16'h1000, '0, '0, '0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    rd_en = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rdata", acc_read_data, '0);
    chk("abort_rvalid", 512'(acc_read_data_valid), '0);
    chk("abort_rd_en", 512'(mem_read_en), '0);
    @(posedge clk); #1;
    t = cyc;
    rd_addr[0*AW +: AW] = 16'h0800;
    rd_addr[3*AW +: AW] = 16'h3300;
    rd_en = 4'b1001;
    exp_rd(t + 1, 16'h0800, 4'b0001);
    exp_rd(t + 5, 16'h3300, 4'b1000);
    drain("reset_wait");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
